// File: rtl/brlwe_pkg.sv
// Shared types and constants for the BRLWE decryption sequencer.
// Holds the sequencer state encoding, default sizing and text_in slice helpers.
// No logic of its own; imported by the sequencer and its watchdog.
package brlwe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int N_DEFAULT       = 256;
  localparam int CW_DEFAULT      = 8;
  localparam int TIMEOUT_DEFAULT = 65535;

  // Bit offset of c2 coefficient idx inside text_in (c2 occupies the low half).
  function automatic int c2_offset(input int cw, input int idx);
    return idx * cw;
  endfunction

  // Bit offset of c1 coefficient idx inside text_in (c1 occupies the high half).
  function automatic int c1_offset(input int n, input int cw, input int idx);
    return n * cw + idx * cw;
  endfunction

endpackage

// File: rtl/brlwe_wdt.sv
// Saturating watchdog: counts consecutive enabled cycles since the last clear.
// expired is combinational and flags the TIMEOUT-th consecutive enabled cycle.
// No backpressure; clear has priority over enable.
module brlwe_wdt
  import brlwe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT);
  localparam logic [WW-1:0] TERM  = WW'(TIMEOUT - 1);

  logic [WW-1:0] count;

  // Count enabled cycles, holding at LIMIT instead of wrapping.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // The current cycle is the TIMEOUT-th one without a clear once count reaches TIMEOUT-1.
  assign expired = enable && (count >= TERM);

endmodule

// File: rtl/brlwe_seq.sv
// Sequencer: loads N key bits and c1/c2 pairs into the BRLWE core, then collects N plaintext bits.
// Latency start->done = N + 1 + core processing + 1 cycles; load outputs are registered.
// Host start is ignored while busy; a stalled core is abandoned after TIMEOUT idle cycles.
module brlwe_seq
  import brlwe_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int CW      = CW_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [N-1:0]      key,
  input  logic [2*N*CW-1:0] text_in,
  output logic              core_load,
  output logic              core_m_in,
  output logic [CW-1:0]     core_c1,
  output logic [CW-1:0]     core_c2,
  input  logic              core_m_out,
  input  logic              core_valid,
  output logic [N-1:0]      result,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              trig
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int OW = $clog2(2 * N * CW);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t        state, state_next;
  logic [IW-1:0] in_idx, in_idx_next;
  logic [IW-1:0] out_idx;
  logic          accept, capture, timed_out;
  logic          wdt_clear, wdt_enable, wdt_expired;
  logic [OW-1:0] c1_pos, c2_pos;

  // Watchdog runs only while collecting and restarts on every valid bit.
  assign wdt_clear  = (state != COLLECT) || core_valid;
  assign wdt_enable = (state == COLLECT) && !core_valid;

  brlwe_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (wdt_clear),
    .enable  (wdt_enable),
    .expired (wdt_expired)
  );

  // Next-state logic; a valid bit always beats a simultaneous watchdog expiry.
  always_comb begin
    state_next  = state;
    in_idx_next = in_idx;
    accept      = 1'b0;
    capture     = 1'b0;
    timed_out   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = LOAD;
          in_idx_next = '0;
          accept      = 1'b1;
        end
      end
      LOAD: begin
        if (in_idx == LAST_IDX) begin
          state_next  = COLLECT;
          in_idx_next = '0;
        end else begin
          in_idx_next = in_idx + 1'b1;
        end
      end
      COLLECT: begin
        if (core_valid) begin
          capture = 1'b1;
          if (out_idx == LAST_IDX) begin
            state_next = DONE;
          end
        end else if (wdt_expired) begin
          state_next = IDLE;
          timed_out  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Slice positions of the coefficient pair for the index presented next cycle.
  assign c1_pos = OW'(c1_offset(N, CW, int'(in_idx_next)));
  assign c2_pos = OW'(c2_offset(CW, int'(in_idx_next)));

  // State and index registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      in_idx <= '0;
    end else begin
      state  <= state_next;
      in_idx <= in_idx_next;
    end
  end

  // Registered core load interface: index i is driven in the i-th LOAD cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      core_load <= 1'b0;
      core_m_in <= 1'b0;
      core_c1   <= '0;
      core_c2   <= '0;
    end else if (state_next == LOAD) begin
      core_load <= 1'b1;
      core_m_in <= key[in_idx_next];
      core_c1   <= text_in[c1_pos +: CW];
      core_c2   <= text_in[c2_pos +: CW];
    end else begin
      core_load <= 1'b0;
      core_m_in <= 1'b0;
      core_c1   <= '0;
      core_c2   <= '0;
    end
  end

  // Result capture, output index and sticky timeout flag; a new start clears them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_idx     <= '0;
      result      <= '0;
      timeout_err <= 1'b0;
    end else if (accept) begin
      out_idx     <= '0;
      result      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (capture) begin
        result[out_idx] <= core_m_out;
        out_idx         <= (out_idx == LAST_IDX) ? '0 : out_idx + 1'b1;
      end
      if (timed_out) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign trig = core_load;

endmodule

// File: tb/tb_brlwe_seq.sv
// Self-checking bench for brlwe_seq with an edge-timestamp reference model.
// Runs basic, ignored-start, timeout, mid-load reset, random and watchdog-boundary operations.
// Stimulus is driven on the falling edge; outputs are compared on the falling edge.
module tb_brlwe_seq;

  localparam int N  = 256;
  localparam int CW = 8;
  localparam int TO = 1000;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [N-1:0]      key = '0;
  logic [2*N*CW-1:0] text_in = '0;
  logic              core_m_out = 1'b0;
  logic              core_valid = 1'b0;
  logic              core_load, core_m_in, busy, done, timeout_err, trig;
  logic [CW-1:0]     core_c1, core_c2;
  logic [N-1:0]      result;

  brlwe_seq #(.N(N), .CW(CW), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .key         (key),
    .text_in     (text_in),
    .core_load   (core_load),
    .core_m_in   (core_m_in),
    .core_c1     (core_c1),
    .core_c2     (core_c2),
    .core_m_out  (core_m_out),
    .core_valid  (core_valid),
    .result      (result),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .trig        (trig)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operands as plain arrays; packed into key/text_in before each operation.
  bit          keyb[N];
  logic [CW-1:0] c1a[N];
  logic [CW-1:0] c2a[N];

  // Reference model: tracks the operation by edge timestamps.
  int           ecnt = 0;
  int           t0 = 0, nval = 0, last_ref = 0, exp_idx = 0;
  bit           m_active = 0, m_done = 0, m_terr = 0, exp_load = 0;
  logic [N-1:0] m_res = '0;

  initial begin
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        m_active = 0; m_done = 0; m_terr = 0; m_res = '0; exp_load = 0;
      end else begin
        ecnt++;
        if (m_done) begin
          m_done = 0; m_active = 0;
        end else if (!m_active) begin
          if (start) begin
            m_active = 1; t0 = ecnt; m_res = '0; m_terr = 0; nval = 0; last_ref = ecnt + N;
          end
        end else if (ecnt > t0 + N) begin
          if (core_valid) begin
            m_res[nval] = core_m_out;
            nval++;
            last_ref = ecnt;
            if (nval == N) m_done = 1;
          end else if (ecnt - last_ref >= TO) begin
            m_active = 0; m_terr = 1;
          end
        end
        exp_load = m_active && (ecnt - t0 < N);
        exp_idx  = ecnt - t0;
      end
    end
  end

  // Compare process: every cycle, all outputs against the model.
  logic          e_min;
  logic [CW-1:0] e_c1, e_c2;
  initial begin
    forever begin
      @(negedge clock);
      e_min = 1'b0; e_c1 = '0; e_c2 = '0;
      if (exp_load) begin
        e_min = keyb[exp_idx]; e_c1 = c1a[exp_idx]; e_c2 = c2a[exp_idx];
      end
      check("core_load", core_load, exp_load);
      check("trig", trig, exp_load);
      check("core_m_in", core_m_in, e_min);
      check("core_c1", core_c1, e_c1);
      check("core_c2", core_c2, e_c2);
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("timeout_err", timeout_err, m_terr);
      check("result", result, m_res);
    end
  end

  // Output activity counters for per-operation literal checks.
  int load_cyc = 0, done_cyc = 0;
  initial begin
    forever begin
      @(negedge clock);
      if (core_load) load_cyc++;
      if (done) done_cyc++;
    end
  end

  logic [N-1:0] a5_vec;

  task automatic run_op(input bit basic, input bit inj, input bit spur,
                        input int stop_after, input int final_gap, input int rst_at);
    int l0, d0, gap, k;
    logic [7:0] pat;
    pat = 8'hA5;
    for (int i = 0; i < N; i++) begin
      if (basic) begin
        keyb[i] = 1'b1; c1a[i] = CW'(i); c2a[i] = CW'(255 - i);
      end else begin
        keyb[i] = 1'($urandom_range(0, 1)); c1a[i] = CW'($urandom); c2a[i] = CW'($urandom);
      end
      key[i] = keyb[i];
      text_in[i*CW +: CW] = c2a[i];
      text_in[N*CW + i*CW +: CW] = c1a[i];
    end
    l0 = load_cyc; d0 = done_cyc;
    if (spur) begin
      core_valid = 1'b1; core_m_out = 1'b1;
      repeat (3) @(negedge clock);
    end
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check("terr_cleared_by_start", timeout_err, 1'b0);
    for (int i = 1; i <= N; i++) begin
      @(negedge clock);
      if (i == N - 1) core_valid = 1'b0;
      if (inj) start = (i == 50);
      if (basic && i == 5) begin
        check("idx5_m_in", core_m_in, 1'b1);
        check("idx5_c1", core_c1, 8'h05);
        check("idx5_c2", core_c2, 8'hFA);
      end
      if (i == rst_at) begin
        #2 resetn = 1'b0;
        #1;
        check("rst_load", core_load, 1'b0);
        check("rst_trig", trig, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_result", result, '0);
        check("rst_c1c2", {core_c1, core_c2, core_m_in}, '0);
        check("rst_done_terr", {done, timeout_err}, '0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        return;
      end
    end
    if (spur) check("spur_result", result, '0);
    for (int j = 0; j < N; j++) begin
      if (stop_after >= 0 && j == stop_after) break;
      gap = (final_gap > 0 && j == N - 1) ? final_gap - 1 : int'($urandom_range(0, 3));
      core_valid = 1'b0;
      repeat (gap) @(negedge clock);
      core_valid = 1'b1;
      core_m_out = basic ? pat[j % 8] : 1'($urandom_range(0, 1));
      if (inj && j == 10) start = 1'b1;
      @(negedge clock);
      core_valid = 1'b0; start = 1'b0;
    end
    k = 0;
    while (busy && k < 3 * TO) begin
      @(negedge clock);
      k++;
    end
    check("reached_idle", busy, 1'b0);
    if (stop_after < 0 && final_gap != TO + 1) begin
      check("load_cycles", load_cyc - l0, N);
      check("done_pulses", done_cyc - d0, 1);
      check("terr_clear", timeout_err, 1'b0);
    end else begin
      check("no_done", done_cyc - d0, 0);
      check("terr_set", timeout_err, 1'b1);
    end
    if (stop_after >= 0) begin
      check("to_latency", k, TO);
      check("to_upper_zero", result >> stop_after, '0);
    end
    if (basic) begin
      check("result_a5", result, a5_vec);
      check("model_pin_a5", m_res, a5_vec);
    end
  endtask

  initial begin
    logic [7:0] p;
    p = 8'hA5;
    for (int i = 0; i < N; i++) a5_vec[i] = p[i % 8];
    repeat (2) @(negedge clock);
    check("reset_outputs", {core_load, trig, busy, done, timeout_err, core_m_in}, '0);
    check("reset_result", result, '0);
    resetn = 1'b1;
    @(negedge clock);
    run_op(1, 0, 0, -1, -1, -1);   // basic A5 run
    run_op(1, 1, 1, -1, -1, -1);   // ignored starts, spurious valids
    run_op(0, 0, 0, 100, -1, -1);  // core stalls after 100 bits
    run_op(0, 0, 0, -1, -1, 128);  // reset in the middle of LOAD
    run_op(0, 0, 0, -1, -1, -1);   // clean random run after reset
    run_op(0, 0, 0, -1, TO, -1);   // final valid coincides with watchdog terminal
    run_op(0, 0, 0, -1, TO + 1, -1); // final valid one cycle too late
    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "bench time limit expired");
  end

endmodule

// File: doc/brlwe_seq.md
# brlwe_seq

Sequencer for the bit-serial BRLWE decryption core. Upon a host start pulse, it streams N secret-key bits and N c1/c2 coefficient pairs into the core. It then collects N serial plaintext bits into a result register and reports completion or timeout. It sits between the host interface (key/text/start/result) and the BRLWE core, and replaces ad-hoc counters in the top level.

## Interface
- N, 256, number of coefficients / key bits / result bits
- CW, 8, coefficient width in bits
- TIMEOUT, 65535, max cycles between consecutive core_valid pulses while collecting
- clock  in  1  system clock
- resetn  in  1  reset resetn, asynchronous, active-low
- start  in  1  one-cycle start request from host interface
- key  in  N  secret key bits; bit i sent at load index i
- text_in  in  2*N*CW  c2 coefficient i at [i*CW+:CW]; c1 coefficient i at [N*CW+i*CW+:CW]
- core_load  out  1  load strobe to core
- core_m_in  out  1  key bit for current load index
- core_c1  out  CW  c1 coefficient for current load index
- core_c2  out  CW  c2 coefficient for current load index
- core_m_out  in  1  serial plaintext bit from core
- core_valid  in  1  core_m_out qualifier
- result  out  N  collected plaintext; bit j = j-th valid bit
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- timeout_err  out  1  sticky error flag, cleared by next accepted start
- trig  out  1  scope trigger, high exactly while core_load is high

## Operation
- States: IDLE, LOAD, COLLECT, DONE.
- IDLE: start=1 → LOAD, in_idx=0, out_idx=0, result cleared to 0, timeout_err cleared. start in any other state is ignored.
- LOAD: registered outputs core_load=1, core_m_in=key[in_idx], core_c1/core_c2 = coefficient in_idx. in_idx increments each cycle. After in_idx=N-1 is presented → COLLECT.
- COLLECT: core_valid=1 → result[out_idx]<=core_m_out, out_idx++, watchdog cleared. Valid at out_idx=N-1 → DONE. Watchdog increments on cycles without valid. Watchdog reaching TIMEOUT → IDLE with timeout_err=1, done not pulsed, partial result kept.
- DONE: done=1 for one cycle → IDLE.
- core_valid outside COLLECT: ignored, result unchanged.
- Counter widths: in_idx/out_idx $clog2(N) bits, terminal count compared explicitly (no reliance on wrap). Watchdog $clog2(TIMEOUT+1) bits, saturating.
- Reset (any time, including mid-LOAD/COLLECT): state=IDLE. core_load, core_m_in, core_c1, core_c2, result, busy, done, timeout_err, trig all 0. Counters 0.

## Timing
- start sampled at edge T → core_load high edges T+1..T+N (N cycles), index i visible in cycle T+1+i.
- busy high from T+1 through the DONE cycle inclusive. Low in IDLE.
- done asserts the cycle after the edge sampling the final core_valid. busy drops the cycle after done.
- key/text_in must be held stable by the host from start until core_load falls. They are not latched.
- Latency start→done = N + 1 + (core processing) + 1 cycles.
- Simultaneous final core_valid and watchdog terminal count: valid wins → DONE.

## Structure
- Package brlwe_pkg: state enum (IDLE, LOAD, COLLECT, DONE), default N, CW, TIMEOUT constants, and the text_in slice offset function for c1/c2.
- One sub-module, brlwe_wdt: resettable saturating watchdog counter (inputs clear, enable; output expired). The remaining logic stays flat.

## Test plan
- Basic run, N=256: key=all ones, c1[i]=i, c2[i]=255-i, start at T → core_load high T+1..T+256, cycle T+1+5 shows m_in=1, c1=0x05, c2=0xFA. Core model returns pattern 0xA5 repeated → result=0xA5..A5, done one pulse, timeout_err=0.
- Start during LOAD and COLLECT → ignored: core_load still exactly 256 cycles, single done.
- Core model withholds valids after bit 100, TIMEOUT=1000 → IDLE 1000 cycles after the last valid, timeout_err=1, result[99:0] captured, rest 0, no done. The next start clears timeout_err.
- resetn pulsed low at cycle 128 of LOAD → all outputs 0 immediately. After release, a new start produces a clean full run.
- Spurious core_valid=1 in IDLE and LOAD → result stays 0, no state change.
- Final valid coincident with watchdog expiry (TIMEOUT=4, valid gap exactly 4) → done=1, timeout_err=0.
